// File: rtl/imm_pkg.sv
// Shared types for the immediate-generation pipeline: format encodings and buffer entry layout.
// Buffer entries are sized for the widest legal configuration; unused upper bits are constant zero.
package imm_pkg;

    typedef enum logic [2:0] {
        ImmI     = 3'b000,
        ImmS     = 3'b001,
        ImmB     = 3'b010,
        ImmJ     = 3'b011,
        ImmU     = 3'b100,
        ImmShamt = 3'b101,
        ImmZimm  = 3'b110,
        ImmRsvd  = 3'b111
    } immsrc_e;

    localparam int unsigned ImmWMax = 64;
    localparam int unsigned TagWMax = 16;

    typedef struct packed {
        logic [ImmWMax-1:0] imm;
        logic [TagWMax-1:0] tag;
        logic               illegal;
    } imm_entry_t;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Upstream instruction and downstream immediate handshakes of imm_gen_pipe.
// master drives entries in and consumes results; slave is the pipeline itself.
interface imm_gen_pipe_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [2:0]       in_immsrc;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    modport master (
        output in_valid, in_instr, in_immsrc, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_immsrc, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_illegal
    );
endinterface

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate extraction for one instruction word.
// Format 110 (CSR uimm) is decoded only when IMM_GEN_ZIMM_EN is defined; otherwise it is reserved.
module imm_decode
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  immsrc_e         immsrc_i,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    // Opcode bits never contribute to any immediate.
    logic unused_opcode;
    assign unused_opcode = ^instr_i[6:0];

    always_comb begin
        imm_o     = '0;
        illegal_o = 1'b0;
        unique case (immsrc_i)
            ImmI:     imm_o = XLEN'($signed(instr_i[31:20]));
            ImmS:     imm_o = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
            ImmB:     imm_o = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                             instr_i[11:8], 1'b0}));
            ImmJ:     imm_o = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                             instr_i[30:21], 1'b0}));
            ImmU:     imm_o = XLEN'($signed({instr_i[31:12], 12'b0}));
            ImmShamt: imm_o = (XLEN == 64) ? XLEN'(instr_i[25:20]) : XLEN'(instr_i[24:20]);
`ifdef IMM_GEN_ZIMM_EN
            ImmZimm:  imm_o = XLEN'(instr_i[19:15]);
`endif
            default: begin
                imm_o     = '0;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator followed by a DEPTH-entry in-order output buffer with valid/ready handshakes.
// Optional macro IMM_GEN_ZIMM_EN enables the CSR uimm format in imm_decode.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    imm_gen_pipe_if.slave  bus
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    imm_entry_t      mem_q [DEPTH];
    imm_entry_t      mem_d [DEPTH];

    logic            push;
    logic            pop;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    imm_entry_t      new_entry;
    imm_entry_t      head;

    imm_decode #(
        .XLEN (XLEN)
    ) u_imm_decode (
        .instr_i   (bus.in_instr),
        .immsrc_i  (immsrc_e'(bus.in_immsrc)),
        .imm_o     (dec_imm),
        .illegal_o (dec_illegal)
    );

    // Readiness depends only on registered occupancy, never on same-cycle out_ready.
    assign bus.in_ready  = (count_q < CntW'(DEPTH));
    assign bus.out_valid = (count_q != '0);

    assign push = bus.in_valid & bus.in_ready & ~flush;
    assign pop  = bus.out_valid & bus.out_ready & ~flush;

    always_comb begin
        new_entry         = '0;
        new_entry.imm     = ImmWMax'(dec_imm);
        new_entry.tag     = TagWMax'(bus.in_tag);
        new_entry.illegal = dec_illegal;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = new_entry;
                wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    // Head is read straight from storage, so it stays stable while the consumer stalls.
    assign head            = mem_q[rd_ptr_q];
    assign bus.out_imm     = head.imm[XLEN-1:0];
    assign bus.out_tag     = head.tag[TAG_W-1:0];
    assign bus.out_illegal = head.illegal;

    logic unused_head;
    assign unused_head = ^{head.imm, head.tag};

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: XLEN=32 and XLEN=64 instances share stimulus and are compared each cycle
// against a queue-based reference model, plus directed literal checks.
module tb_imm_gen_pipe;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_immsrc;
    logic [4:0]  in_tag;
    logic        out_ready;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) bus64 ();

    assign bus32.in_valid  = in_valid;
    assign bus32.in_instr  = in_instr;
    assign bus32.in_immsrc = in_immsrc;
    assign bus32.in_tag    = in_tag;
    assign bus32.out_ready = out_ready;
    assign bus64.in_valid  = in_valid;
    assign bus64.in_instr  = in_instr;
    assign bus64.in_immsrc = in_immsrc;
    assign bus64.in_tag    = in_tag;
    assign bus64.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(5)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus32)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(5)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference immediate computed arithmetically from the field definitions.
    function automatic logic [63:0] ref_imm(input int xlen, input logic [31:0] ins,
                                            input logic [2:0] src, output logic ill);
        longint u;
        longint v;
        u   = longint'({32'b0, ins});
        v   = 0;
        ill = 1'b0;
        case (src)
            3'd0: begin
                v = (u >> 20) & 64'hFFF;
                if (v >= 2048) v = v - 4096;
            end
            3'd1: begin
                v = ((u >> 25) & 127) * 32 + ((u >> 7) & 31);
                if (v >= 2048) v = v - 4096;
            end
            3'd2: begin
                v = ((u >> 31) & 1) * 4096 + ((u >> 7) & 1) * 2048
                  + ((u >> 25) & 63) * 32 + ((u >> 8) & 15) * 2;
                if (v >= 4096) v = v - 8192;
            end
            3'd3: begin
                v = ((u >> 31) & 1) * 1048576 + ((u >> 12) & 255) * 4096
                  + ((u >> 20) & 1) * 2048 + ((u >> 21) & 1023) * 2;
                if (v >= 1048576) v = v - 2097152;
            end
            3'd4: begin
                v = u & 64'hFFFF_F000;
                if (v >= 64'h8000_0000) v = v - 64'h1_0000_0000;
            end
            3'd5: v = (u >> 20) & ((xlen == 64) ? 63 : 31);
`ifdef IMM_GEN_ZIMM_EN
            3'd6: v = (u >> 15) & 31;
`endif
            default: begin
                v   = 0;
                ill = 1'b1;
            end
        endcase
        if (xlen == 32) v = v & 64'hFFFF_FFFF;
        return 64'(v);
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [4:0]  tag;
    } ent_t;

    ent_t mq[$];

    always @(posedge clk or negedge rst_n) begin
        ent_t e;
        bit   do_push;
        bit   do_pop;
        if (!rst_n) begin
            mq.delete();
        end else begin
            do_push = in_valid && (mq.size() < DEPTH) && !flush;
            do_pop  = (mq.size() > 0) && out_ready && !flush;
            e.instr = in_instr;
            e.src   = in_immsrc;
            e.tag   = in_tag;
            if (flush) begin
                mq.delete();
            end else begin
                if (do_pop) mq.delete(0);
                if (do_push) mq.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        logic [63:0] e32;
        logic [63:0] e64;
        logic        ill;
        if (rst_n) begin
            chk("in_ready32", 64'(bus32.in_ready), 64'(mq.size() < DEPTH));
            chk("in_ready64", 64'(bus64.in_ready), 64'(mq.size() < DEPTH));
            chk("out_valid32", 64'(bus32.out_valid), 64'(mq.size() != 0));
            chk("out_valid64", 64'(bus64.out_valid), 64'(mq.size() != 0));
            if (mq.size() != 0) begin
                e32 = ref_imm(32, mq[0].instr, mq[0].src, ill);
                e64 = ref_imm(64, mq[0].instr, mq[0].src, ill);
                chk("out_imm32", 64'(bus32.out_imm), e32);
                chk("out_imm64", bus64.out_imm, e64);
                chk("out_tag32", 64'(bus32.out_tag), 64'(mq[0].tag));
                chk("out_tag64", 64'(bus64.out_tag), 64'(mq[0].tag));
                chk("out_illegal32", 64'(bus32.out_illegal), 64'(ill));
                chk("out_illegal64", 64'(bus64.out_illegal), 64'(ill));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fmt(input string name, input logic [31:0] ins, input logic [2:0] src,
                       input logic [63:0] e32, input logic [63:0] e64, input logic eill);
        in_valid  = 1'b1;
        in_instr  = ins;
        in_immsrc = src;
        in_tag    = 5'd7;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk({name, "_valid"}, 64'(bus32.out_valid), 64'd1);
        chk({name, "_imm32"}, 64'(bus32.out_imm), e32);
        chk({name, "_imm64"}, bus64.out_imm, e64);
        chk({name, "_ill"}, 64'(bus32.out_illegal), 64'(eill));
        step();
    endtask

    task automatic reset_checks(input string name);
        chk({name, "_valid"}, 64'(bus32.out_valid), 64'd0);
        chk({name, "_ready"}, 64'(bus32.in_ready), 64'd1);
        chk({name, "_imm32"}, 64'(bus32.out_imm), 64'd0);
        chk({name, "_imm64"}, bus64.out_imm, 64'd0);
        chk({name, "_tag"}, 64'(bus32.out_tag), 64'd0);
        chk({name, "_ill"}, 64'(bus32.out_illegal), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_immsrc = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        #3;
        reset_checks("reset");
        #9 rst_n = 1'b1;

        // First edge after reset release accepts an entry.
        fmt("fmt_i", 32'hFFF0_0093, 3'd0, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        fmt("fmt_b", 32'hFE00_0EE3, 3'd2, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        fmt("fmt_u", 32'h1234_5037, 3'd4, 64'h1234_5000, 64'h1234_5000, 1'b0);
        fmt("fmt_u_neg", 32'h8000_0037, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0);
        fmt("fmt_shamt", 32'h03F0_1013, 3'd5, 64'h1F, 64'h3F, 1'b0);
        // instr[19:15] of 0x0000D073 is 5'b00001.
`ifdef IMM_GEN_ZIMM_EN
        fmt("fmt_zimm", 32'h0000_D073, 3'd6, 64'h1, 64'h1, 1'b0);
`else
        fmt("fmt_zimm", 32'h0000_D073, 3'd6, 64'h0, 64'h0, 1'b1);
`endif
        fmt("fmt_rsvd", 32'h0000_D073, 3'd7, 64'h0, 64'h0, 1'b1);

        // Backpressure: three pushes into a two-entry buffer with the consumer stalled.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_immsrc = 3'd0;
        in_instr  = 32'h0010_0093;
        in_tag    = 5'd1;
        step();
        in_tag = 5'd2;
        step();
        in_tag = 5'd3;
        chk("bp_full_ready", 64'(bus32.in_ready), 64'd0);
        step();
        chk("bp_held_ready", 64'(bus32.in_ready), 64'd0);
        chk("bp_head1", 64'(bus32.out_tag), 64'd1);
        out_ready = 1'b1;
        step();
        chk("bp_head2", 64'(bus32.out_tag), 64'd2);
        chk("bp_ready_again", 64'(bus32.in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("bp_head3", 64'(bus32.out_tag), 64'd3);
        step();
        chk("bp_empty", 64'(bus32.out_valid), 64'd0);

        // Flush of a full buffer drops the same-cycle input too.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        step();
        step();
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 64'(bus32.out_valid), 64'd0);
        chk("flush_ready", 64'(bus32.in_ready), 64'd1);
        step();
        chk("flush_dropped", 64'(bus32.out_valid), 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_instr  = $urandom;
            in_immsrc = 3'($urandom_range(0, 7));
            in_tag    = 5'($urandom);
            step();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Asynchronous reset in the middle of buffered traffic.
        in_valid  = 1'b1;
        in_immsrc = 3'd0;
        in_instr  = 32'hFFF0_0093;
        step();
        step();
        in_valid = 1'b0;
        step();
        chk("midrst_pre_valid", 64'(bus32.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        reset_checks("midrst");
        #3 rst_n = 1'b1;
        in_valid  = 1'b1;
        in_immsrc = 3'd4;
        in_instr  = 32'h1234_5037;
        in_tag    = 5'd9;
        step();
        in_valid = 1'b0;
        chk("postrst_valid", 64'(bus32.out_valid), 64'd1);
        chk("postrst_tag", 64'(bus32.out_tag), 64'd9);
        out_ready = 1'b1;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
